vdp_port: RTL
=============

VDP_PORT -- requirements
Module: vdp_port

Interface
REQ-001 Parameter ADDR_W, default 14, VRAM address width; legal values 14..17.
REQ-002 Parameter NUM_REGS, default 8, count of 8-bit control registers; power of two, 8..64.
REQ-003 Parameter HI_REG, default 14, register index supplying VRAM address bits above 13; used only when ADDR_W>14.
REQ-004 clk  in  1  system clock (cpuClock domain).
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_en  in  1  one-cycle CPU access strobe; ports are sampled only when high.
REQ-007 port  in  2  port select: 0 data (0x98), 1 control/status (0x99), 3 indirect register (0x9B); 2 is ignored.
REQ-008 wr, rd  in  1 each  CPU I/O write/read qualifiers; both high together is ignored.
REQ-009 cpu_din  in  8  CPU write data.
REQ-010 cpu_dout  out  8  CPU read data; registered; valid the cycle after the strobe.
REQ-011 wait_n  out  1  low while a VRAM transaction is pending.
REQ-012 vram_req, vram_we  out  1 each  VRAM request and write qualifier.
REQ-013 vram_addr  out  ADDR_W  VRAM address.
REQ-014 vram_wdata  out  8  VRAM write data.
REQ-015 vram_ack  in  1  one-cycle completion pulse; read data is valid with it.
REQ-016 vram_rdata  in  8  VRAM read data.
REQ-017 vblank  in  1  one-cycle frame-end pulse.
REQ-018 status_in  in  7  live status bits [6:0] from the renderer.
REQ-019 regs  out  NUM_REGS*8  flattened control registers; register k occupies bits [8k+7:8k].
REQ-020 int_n  out  1  active-low interrupt.

Function
REQ-021 Control port: a two-byte FSM (FIRST, SECOND); a write in FIRST latches the byte and moves to SECOND.
REQ-022 Write in SECOND with bit7=1: register (bit5:0 mod NUM_REGS) takes the latched byte; the FSM returns to FIRST.
REQ-023 Write in SECOND with bit7=0: address[13:0] takes {bit5:0, latch}; the FSM returns to FIRST.
REQ-024 In case REQ-023 with bit6=0, a read-ahead is issued and its ack loads the read buffer.
REQ-025 Any control-port read forces the FSM to FIRST.
REQ-026 Data-port write issues a VRAM write of cpu_din, loads the read buffer with cpu_din, then increments the address.
REQ-027 Data-port read returns the read buffer, then issues a read-ahead at the current address and increments the address.
REQ-028 vram_req rises the cycle after the triggering strobe and holds stable with addr/data until vram_ack; wait_n = !vram_req.
REQ-029 A data-port access while vram_req is high is dropped; the bench must never present one.
REQ-030 Increment wraps address[13:0] 3FFF->0000; when ADDR_W>14, regs[HI_REG][ADDR_W-15:0] increments with carry modulo its width.
REQ-031 vram_addr = {regs[HI_REG][ADDR_W-15:0], address[13:0]}; when ADDR_W=14 it is address[13:0].
REQ-032 Status read returns {F, status_in}, then clears F.
REQ-033 vblank sets F; if vblank and a status read coincide, F stays set and the read returns the old F.
REQ-034 int_n = !(F & regs[1][5]), registered.
REQ-035 Port 3 write: loads register regs[17][5:0] mod NUM_REGS; if regs[17][7]=0, regs[17][5:0] then increments. Ignored when NUM_REGS<32.

Reset
REQ-036 Reset gives: FSM=FIRST; address, latch, read buffer, F and all regs = 0; vram_req=0, vram_we=0; cpu_dout=00; wait_n=1; int_n=1.
REQ-037 Reset mid-transaction drops vram_req in the same cycle; a late vram_ack is ignored.

Structure
REQ-038 A shared package holds the port codes, the FSM state enum and the status-bit index constants.
REQ-039 Sub-module vdp_addr_counter holds the 14-bit counter, the HI_REG carry and the load path.

Verification
REQ-040 Control 0x00 then 0x40, then data writes 0xAA, 0x55 -> VRAM writes at 0000 then 0001; addr=0002.
REQ-041 Control 0x00, 0x00 (read setup), ack with 0x11, then data read -> 0x11; next req addr=0001.
REQ-042 Control 0xF0, 0x87 -> regs[7]=F0; with regs[1]=0x20, vblank -> int_n=0; status read -> bit7=1, then int_n=1.
REQ-043 ADDR_W=17: regs[14]=0x03, address 3FFF, data write -> vram_addr 0FFFF; after it, regs[14]=0x04, addr=0000.
REQ-044 Control write 0x12, status read, then control 0x34, 0x80 -> regs[0]=0x34 (FSM was reset by the read).
REQ-045 NUM_REGS=64: regs[17]=0x02, port-3 writes 0xA1, 0xB2 -> regs[2]=A1, regs[3]=B2, regs[17]=0x04.

Source files
------------

// File: rtl/vdp_port_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vdp_port_pkg
// Purpose  : Shared constants and types for the VDP CPU port: I/O port codes,
//            control-port byte FSM states, status/control bit positions.
// Revision : 1.0 - initial release
// ============================================================================
package vdp_port_pkg;

    // CPU I/O port selects (0x98, 0x99, 0x9B); code 2 is unused
    localparam logic [1:0] c_port_data = 2'd0;
    localparam logic [1:0] c_port_ctrl = 2'd1;
    localparam logic [1:0] c_port_ireg = 2'd3;

    // Control port two-byte sequencer
    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } ctrl_state_t;

    // Second control byte decode
    localparam int c_cmd_reg_bit    = 7;   // 1: register write, 0: address setup
    localparam int c_cmd_noread_bit = 6;   // 0: address setup issues a read-ahead

    // Status byte: frame flag sits above the live renderer bits
    localparam int c_stat_f_bit = 7;

    // Interrupt enable lives in register 1, bit 5
    localparam int c_ie_reg = 1;
    localparam int c_ie_bit = 5;

    // Indirect register pointer register and its no-increment bit
    localparam int c_ireg_reg       = 17;
    localparam int c_ireg_noinc_bit = 7;

endpackage
`default_nettype wire

// File: rtl/vdp_port_if.sv
`default_nettype none
// ============================================================================
// Module   : vdp_port_if
// Purpose  : CPU bus and VRAM request bus of the VDP port.
//            slave  : the VDP side (samples CPU strobes, drives VRAM requests)
//            master : the CPU/VRAM environment side
// Revision : 1.0 - initial release
// ============================================================================
interface vdp_port_if #(
    parameter int ADDR_W = 14
) ();
    // CPU side
    logic              cpu_en;
    logic [1:0]        port;
    logic              wr;
    logic              rd;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              wait_n;
    // VRAM side
    logic              vram_req;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_ack;
    logic [7:0]        vram_rdata;

    modport slave (
        input  cpu_en, port, wr, rd, cpu_din, vram_ack, vram_rdata,
        output cpu_dout, wait_n, vram_req, vram_we, vram_addr, vram_wdata
    );

    modport master (
        output cpu_en, port, wr, rd, cpu_din, vram_ack, vram_rdata,
        input  cpu_dout, wait_n, vram_req, vram_we, vram_addr, vram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/vdp_addr_counter.sv
`default_nettype none
// ============================================================================
// Module   : vdp_addr_counter
// Purpose  : 14-bit VRAM address counter with load path and carry-out into the
//            high-address register held by the parent.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            i_load/i_load_val - replace the counter this cycle
//            i_inc             - post-increment (applied after any load)
//            i_hi              - current high address bits
//            o_acc_addr        - full address of the access made this cycle
//            o_hi_wr/o_hi_next - high bits must take o_hi_next (14-bit wrap)
// Revision : 1.0 - initial release
// ============================================================================
module vdp_addr_counter #(
    parameter int ADDR_W = 14,
    parameter int HI_W   = 1
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [13:0]       i_load_val,
    input  wire logic              i_inc,
    input  wire logic [HI_W-1:0]   i_hi,
    output logic      [ADDR_W-1:0] o_acc_addr,
    output logic                   o_hi_wr,
    output logic      [HI_W-1:0]   o_hi_next
);
    logic [13:0] r_addr;
    logic [13:0] w_base;
    logic        w_wrap;

    // A load takes effect before the increment so an address setup with a
    // read-ahead accesses the new address and leaves the counter one past it.
    assign w_base    = i_load ? i_load_val : r_addr;
    assign w_wrap    = i_inc && (w_base == 14'h3FFF);
    assign o_hi_wr   = (ADDR_W > 14) && w_wrap;
    assign o_hi_next = i_hi + 1'b1;

    generate
        if (ADDR_W > 14) begin : g_hi
            assign o_acc_addr = {i_hi, w_base};
        end else begin : g_no_hi
            assign o_acc_addr = w_base;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= 14'h0000;
        end else if (i_inc) begin
            r_addr <= w_base + 14'd1;
        end else begin
            r_addr <= w_base;
        end
    end
endmodule
`default_nettype wire

// File: rtl/vdp_port.sv
`default_nettype none
// ============================================================================
// Module   : vdp_port
// Purpose  : CPU-facing port block of a TMS9918-style VDP: control byte pair
//            sequencer, register file, auto-incrementing VRAM address with
//            read-ahead buffer, status/frame flag and interrupt.
// Ports    : clk, reset  - clock, synchronous active-high reset
//            bus         - CPU strobe/data and VRAM request/ack (slave side)
//            vblank      - one-cycle frame-end pulse
//            status_in   - live renderer status bits [6:0]
//            regs        - flattened control registers, reg k at [8k+7:8k]
//            int_n       - active-low interrupt, registered
// Revision : 1.0 - initial release
// ============================================================================
module vdp_port
    import vdp_port_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8,
    parameter int HI_REG   = 14
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    vdp_port_if.slave                  bus,
    input  wire logic                  vblank,
    input  wire logic [6:0]            status_in,
    output logic      [NUM_REGS*8-1:0] regs,
    output logic                       int_n
);
    localparam int  c_hi_w     = (ADDR_W > 14) ? ADDR_W - 14 : 1;
    localparam int  c_rw       = $clog2(NUM_REGS);
    localparam int  c_hi_idx   = HI_REG % NUM_REGS;
    localparam bit  c_has_ireg = (NUM_REGS >= 32);
    localparam int  c_ireg_idx = c_has_ireg ? c_ireg_reg : 0;

    ctrl_state_t                r_state;
    logic [7:0]                 r_latch;
    logic [7:0]                 r_rdbuf;
    logic [7:0]                 r_dout;
    logic [7:0]                 r_wdata;
    logic                       r_flag;
    logic                       r_int_n;
    logic                       r_req;
    logic                       r_we;
    logic [ADDR_W-1:0]          r_vaddr;
    logic [NUM_REGS-1:0][7:0]   r_regs;

    logic                       w_wr_acc;
    logic                       w_rd_acc;
    logic                       w_load;
    logic                       w_inc;
    logic                       w_issue;
    logic                       w_issue_we;
    logic                       w_hi_wr;
    logic [c_hi_w-1:0]          w_hi_next;
    logic [ADDR_W-1:0]          w_acc_addr;
    logic [c_rw-1:0]            w_ireg_ptr;

    assign w_wr_acc   = bus.cpu_en && bus.wr && !bus.rd;
    assign w_rd_acc   = bus.cpu_en && bus.rd && !bus.wr;
    assign w_ireg_ptr = r_regs[c_ireg_idx][c_rw-1:0];

    // Decide whether this strobe loads/advances the address and starts a
    // VRAM cycle. Data accesses while a cycle is pending are dropped.
    always_comb begin
        w_load     = 1'b0;
        w_inc      = 1'b0;
        w_issue    = 1'b0;
        w_issue_we = 1'b0;
        if (w_wr_acc && bus.port == c_port_data && !r_req) begin
            w_inc      = 1'b1;
            w_issue    = 1'b1;
            w_issue_we = 1'b1;
        end
        if (w_wr_acc && bus.port == c_port_ctrl && r_state == ST_SECOND
                && !bus.cpu_din[c_cmd_reg_bit]) begin
            w_load = 1'b1;
            if (!bus.cpu_din[c_cmd_noread_bit] && !r_req) begin
                w_inc   = 1'b1;
                w_issue = 1'b1;
            end
        end
        if (w_rd_acc && bus.port == c_port_data && !r_req) begin
            w_inc   = 1'b1;
            w_issue = 1'b1;
        end
    end

    vdp_addr_counter #(
        .ADDR_W (ADDR_W),
        .HI_W   (c_hi_w)
    ) u_addr (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_load),
        .i_load_val ({bus.cpu_din[5:0], r_latch}),
        .i_inc      (w_inc),
        .i_hi       (r_regs[c_hi_idx][c_hi_w-1:0]),
        .o_acc_addr (w_acc_addr),
        .o_hi_wr    (w_hi_wr),
        .o_hi_next  (w_hi_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FIRST;
            r_latch <= 8'h00;
            r_rdbuf <= 8'h00;
            r_dout  <= 8'h00;
            r_wdata <= 8'h00;
            r_flag  <= 1'b0;
            r_int_n <= 1'b1;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_vaddr <= '0;
            r_regs  <= '0;
        end else begin
            if (r_req && bus.vram_ack) begin
                r_req <= 1'b0;
                r_we  <= 1'b0;
                if (!r_we) begin
                    r_rdbuf <= bus.vram_rdata;
                end
            end
            // Address and data are captured so they hold still until the ack
            // even though the counter has already moved on.
            if (w_issue) begin
                r_req   <= 1'b1;
                r_we    <= w_issue_we;
                r_vaddr <= w_acc_addr;
                r_wdata <= bus.cpu_din;
            end
            if (w_hi_wr) begin
                r_regs[c_hi_idx][c_hi_w-1:0] <= w_hi_next;
            end

            // A coincident status read sees the old flag and vblank wins.
            if (vblank) begin
                r_flag <= 1'b1;
            end else if (w_rd_acc && bus.port == c_port_ctrl) begin
                r_flag <= 1'b0;
            end
            r_int_n <= !(r_flag && r_regs[c_ie_reg][c_ie_bit]);

            if (w_wr_acc) begin
                case (bus.port)
                    c_port_data: begin
                        if (!r_req) begin
                            r_rdbuf <= bus.cpu_din;
                        end
                    end
                    c_port_ctrl: begin
                        if (r_state == ST_FIRST) begin
                            r_latch <= bus.cpu_din;
                            r_state <= ST_SECOND;
                        end else begin
                            r_state <= ST_FIRST;
                            if (bus.cpu_din[c_cmd_reg_bit]) begin
                                r_regs[bus.cpu_din[c_rw-1:0]] <= r_latch;
                            end
                        end
                    end
                    c_port_ireg: begin
                        if (c_has_ireg) begin
                            r_regs[w_ireg_ptr] <= bus.cpu_din;
                            if (!r_regs[c_ireg_idx][c_ireg_noinc_bit]) begin
                                r_regs[c_ireg_idx][5:0] <= r_regs[c_ireg_idx][5:0] + 6'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if (w_rd_acc) begin
                if (bus.port == c_port_data) begin
                    r_dout <= r_rdbuf;
                end else if (bus.port == c_port_ctrl) begin
                    r_dout  <= {r_flag, status_in};
                    r_state <= ST_FIRST;
                end
            end
        end
    end

    // Request is masked by reset so it drops in the reset cycle itself.
    assign bus.vram_req   = r_req && !reset;
    assign bus.wait_n     = !(r_req && !reset);
    assign bus.vram_we    = r_we && !reset;
    assign bus.vram_addr  = r_vaddr;
    assign bus.vram_wdata = r_wdata;
    assign bus.cpu_dout   = r_dout;
    assign regs           = r_regs;
    assign int_n          = r_int_n;
endmodule
`default_nettype wire
